// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline boundary for a core with a synchronous
// instruction ROM. Because the ROM word arrives one advancing edge after its
// address, the PC+1 value is delayed through an alignment stage (pc_pipe) so
// that it meets its instruction in the output stage.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   PC_sumado_in    PC+1 of the address currently on the ROM
//   Instruction_in  ROM output (mem[PC] latched at the last advancing edge)
//   ifid_write      advance enable (shared with PC_write / ROM enable)
//   flush           taken branch/jump, kills wrong-path instructions
//   PC_sumado_out   PC+1 of the instruction presented to ID
//   Instruction_out instruction presented to ID (NOP on bubbles)
//   valid_out       Instruction_out is a real instruction
//   stall_count     saturating count of stall edges
//   bubble_count    saturating count of edges loading a bubble
//
// State  | meaning
// EMPTY  | nothing in flight, output holds a bubble
// PRIMED | ROM word in flight, output still holds a bubble
// RUN    | output holds a valid instruction
// A stall simply freezes whichever state is current.
module if_id_register #(
  parameter int          WIDTH = 32,
  parameter logic [31:0] NOP   = 32'h0000_0000,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] PC_sumado_in,
  input  logic [WIDTH-1:0] Instruction_in,
  input  logic             ifid_write,
  input  logic             flush,
  output logic [WIDTH-1:0] PC_sumado_out,
  output logic [WIDTH-1:0] Instruction_out,
  output logic             valid_out,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] bubble_count
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    PRIMED = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] NOP_W = NOP[WIDTH-1:0];

  state_t           state, state_next;
  logic [WIDTH-1:0] pc_pipe;
  logic             inflight_valid;
  logic             advance;
  logic             stall;
  logic             bubble_inc;

  // Flush dominates ifid_write.
  assign advance = ifid_write & ~flush;
  assign stall   = ~ifid_write & ~flush;

  // A ROM word is in flight in every state except EMPTY.
  assign inflight_valid = (state != EMPTY);

  // Bubble loaded: every flush, or an advance with nothing in flight.
  assign bubble_inc = flush | (advance & ~inflight_valid);

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EMPTY;
    end else if (advance) begin
      case (state)
        EMPTY:   state_next = PRIMED;
        PRIMED:  state_next = RUN;
        RUN:     state_next = RUN;
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= EMPTY;
      pc_pipe         <= '0;
      PC_sumado_out   <= '0;
      Instruction_out <= NOP_W;
      valid_out       <= 1'b0;
    end else begin
      state <= state_next;
      if (flush) begin
        // PC_sumado_out and pc_pipe keep their values; the next advance
        // overwrites pc_pipe with the branch target's PC+1.
        Instruction_out <= NOP_W;
        valid_out       <= 1'b0;
      end else if (advance) begin
        pc_pipe         <= PC_sumado_in;
        PC_sumado_out   <= pc_pipe;
        Instruction_out <= inflight_valid ? Instruction_in : NOP_W;
        valid_out       <= inflight_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
      if (bubble_inc && (bubble_count != {CNT_W{1'b1}}))
        bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule
